// File: rtl/systolic_matmul_if.sv
// Handshake bundle for systolic_matmul: job configuration, X/W operand streams
// and the C result stream.
interface systolic_matmul_if #(
    parameter int NBITS = 16,
    parameter int KW    = 5
);
    logic             cfg_val;
    logic             cfg_rdy;
    logic [KW-1:0]    cfg_k;
    logic             cfg_acc;

    logic             x_recv_val;
    logic             x_recv_rdy;
    logic [NBITS-1:0] x_recv_msg;

    logic             w_recv_val;
    logic             w_recv_rdy;
    logic [NBITS-1:0] w_recv_msg;

    logic             res_send_val;
    logic             res_send_rdy;
    logic [NBITS-1:0] res_send_msg;

    modport slave (
        input  cfg_val, cfg_k, cfg_acc,
        output cfg_rdy,
        input  x_recv_val, x_recv_msg,
        output x_recv_rdy,
        input  w_recv_val, w_recv_msg,
        output w_recv_rdy,
        output res_send_val, res_send_msg,
        input  res_send_rdy
    );

    modport master (
        output cfg_val, cfg_k, cfg_acc,
        input  cfg_rdy,
        output x_recv_val, x_recv_msg,
        input  x_recv_rdy,
        output w_recv_val, w_recv_msg,
        input  w_recv_rdy,
        input  res_send_val, res_send_msg,
        output res_send_rdy
    );
endinterface

// File: rtl/systolic_matmul.sv
// Output-stationary ROWS x COLS systolic array computing C (+)= X*W in signed
// fixed point, with buffered operand vectors, skewed injection and a C stream-out.
module systolic_matmul #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int NBITS = 16,
    parameter int DBITS = 8,
    parameter int KMAX  = 16
) (
    input  logic                clk,
    input  logic                rst,
    systolic_matmul_if.slave    bus,
    output logic                busy_o
);
    localparam int KW   = $clog2(KMAX + 1);
    localparam int XCW  = $clog2(ROWS + 1);
    localparam int WCW  = $clog2(COLS + 1);
    localparam int DCW  = $clog2(ROWS + COLS + 1);
    localparam int NOUT = ROWS * COLS;
    localparam int OCW  = $clog2(NOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_e;

    state_e                  state_q;
    logic [KW-1:0]           k_q;
    logic [KW-1:0]           issued_q;
    logic [DCW-1:0]          drain_q;
    logic [OCW-1:0]          out_idx_q;
    logic [XCW-1:0]          x_cnt_q;
    logic [WCW-1:0]          w_cnt_q;
    logic signed [NBITS-1:0] x_buf_q  [ROWS];
    logic signed [NBITS-1:0] w_buf_q  [COLS];
    logic signed [NBITS-1:0] x_pipe_q [ROWS][COLS];
    logic signed [NBITS-1:0] w_pipe_q [ROWS][COLS];
    logic signed [NBITS-1:0] acc_q    [NOUT];

    logic                        x_full_s;
    logic                        w_full_s;
    logic                        more_s;
    logic                        x_rdy_s;
    logic                        w_rdy_s;
    logic                        x_fire_s;
    logic                        w_fire_s;
    logic                        issue_s;
    logic                        cfg_rdy_s;
    logic                        cfg_fire_s;
    logic                        out_fire_s;
    logic [KW-1:0]               k_lim_s;
    logic [NBITS-1:0]            res_msg_s;
    logic [ROWS-1:0][NBITS-1:0]  x_inj_s;
    logic [ROWS-1:0][NBITS-1:0]  x_in_s;
    logic [COLS-1:0][NBITS-1:0]  w_inj_s;
    logic [COLS-1:0][NBITS-1:0]  w_in_s;

    function automatic logic signed [NBITS-1:0] mac_term(
        input logic signed [NBITS-1:0] a,
        input logic signed [NBITS-1:0] b
    );
        logic signed [2*NBITS-1:0] prod;
        prod     = (2*NBITS)'(a) * (2*NBITS)'(b);
        mac_term = NBITS'(prod >>> DBITS);
    endfunction

    assign x_full_s   = (x_cnt_q == XCW'(ROWS));
    assign w_full_s   = (w_cnt_q == WCW'(COLS));
    assign more_s     = (issued_q < k_q);
    assign x_rdy_s    = (state_q == ST_COMPUTE) && !x_full_s && more_s;
    assign w_rdy_s    = (state_q == ST_COMPUTE) && !w_full_s && more_s;
    assign x_fire_s   = bus.x_recv_val && x_rdy_s;
    assign w_fire_s   = bus.w_recv_val && w_rdy_s;
    // Issue only from registered full buffers, never in the cycle the last slot fills.
    assign issue_s    = (state_q == ST_COMPUTE) && x_full_s && w_full_s;
    assign cfg_rdy_s  = (state_q == ST_IDLE) && !rst;
    assign cfg_fire_s = bus.cfg_val && cfg_rdy_s;
    assign out_fire_s = (state_q == ST_OUTPUT) && bus.res_send_rdy;
    assign k_lim_s    = (bus.cfg_k > KW'(KMAX)) ? KW'(KMAX) : bus.cfg_k;

    assign bus.cfg_rdy      = cfg_rdy_s;
    assign bus.x_recv_rdy   = x_rdy_s;
    assign bus.w_recv_rdy   = w_rdy_s;
    assign bus.res_send_val = (state_q == ST_OUTPUT);
    assign bus.res_send_msg = (state_q == ST_OUTPUT) ? res_msg_s : {NBITS{1'b0}};
    assign busy_o           = (state_q != ST_IDLE);

    // Result element selected by the output index.
    always_comb begin
        res_msg_s = {NBITS{1'b0}};
        for (int n = 0; n < NOUT; n++) begin
            res_msg_s = res_msg_s | ((out_idx_q == OCW'(n)) ? acc_q[n] : {NBITS{1'b0}});
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_xrow
        assign x_inj_s[gi] = issue_s ? x_buf_q[gi] : {NBITS{1'b0}};
        if (gi == 0) begin : g_direct
            assign x_in_s[gi] = x_inj_s[gi];
        end else begin : g_chain
            logic [NBITS-1:0] chain_q [gi];
            // Row gi is delayed gi cycles before entering the array.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < gi; s++) chain_q[s] <= {NBITS{1'b0}};
                end else begin
                    chain_q[0] <= x_inj_s[gi];
                    for (int s = 1; s < gi; s++) chain_q[s] <= chain_q[s-1];
                end
            end
            assign x_in_s[gi] = chain_q[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_wcol
        assign w_inj_s[gj] = issue_s ? w_buf_q[gj] : {NBITS{1'b0}};
        if (gj == 0) begin : g_direct
            assign w_in_s[gj] = w_inj_s[gj];
        end else begin : g_chain
            logic [NBITS-1:0] chain_q [gj];
            // Column gj is delayed gj cycles before entering the array.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < gj; s++) chain_q[s] <= {NBITS{1'b0}};
                end else begin
                    chain_q[0] <= w_inj_s[gj];
                    for (int s = 1; s < gj; s++) chain_q[s] <= chain_q[s-1];
                end
            end
            assign w_in_s[gj] = chain_q[gj-1];
        end
    end

    // Operand buffers, PE operand registers and accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt_q <= {XCW{1'b0}};
            w_cnt_q <= {WCW{1'b0}};
            for (int i = 0; i < ROWS; i++) x_buf_q[i] <= {NBITS{1'b0}};
            for (int j = 0; j < COLS; j++) w_buf_q[j] <= {NBITS{1'b0}};
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    x_pipe_q[i][j]      <= {NBITS{1'b0}};
                    w_pipe_q[i][j]      <= {NBITS{1'b0}};
                    acc_q[i*COLS + j]   <= {NBITS{1'b0}};
                end
            end
        end else begin
            if (issue_s)       x_cnt_q <= {XCW{1'b0}};
            else if (x_fire_s) x_cnt_q <= x_cnt_q + XCW'(1);
            if (issue_s)       w_cnt_q <= {WCW{1'b0}};
            else if (w_fire_s) w_cnt_q <= w_cnt_q + WCW'(1);
            for (int i = 0; i < ROWS; i++) begin
                if (x_fire_s && (x_cnt_q == XCW'(i))) x_buf_q[i] <= $signed(bus.x_recv_msg);
            end
            for (int j = 0; j < COLS; j++) begin
                if (w_fire_s && (w_cnt_q == WCW'(j))) w_buf_q[j] <= $signed(bus.w_recv_msg);
            end
            for (int i = 0; i < ROWS; i++) begin
                x_pipe_q[i][0] <= $signed(x_in_s[i]);
                for (int j = 1; j < COLS; j++) x_pipe_q[i][j] <= x_pipe_q[i][j-1];
            end
            for (int j = 0; j < COLS; j++) begin
                w_pipe_q[0][j] <= $signed(w_in_s[j]);
                for (int i = 1; i < ROWS; i++) w_pipe_q[i][j] <= w_pipe_q[i-1][j];
            end
            // Idle slots carry zero operands, so PEs may accumulate every cycle.
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    if (cfg_fire_s && !bus.cfg_acc) begin
                        acc_q[i*COLS + j] <= {NBITS{1'b0}};
                    end else begin
                        acc_q[i*COLS + j] <= acc_q[i*COLS + j] + mac_term(x_pipe_q[i][j], w_pipe_q[i][j]);
                    end
                end
            end
        end
    end

    // Job sequencing: issue counting, drain timing and result indexing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= {KW{1'b0}};
            issued_q  <= {KW{1'b0}};
            drain_q   <= {DCW{1'b0}};
            out_idx_q <= {OCW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_fire_s) begin
                        k_q       <= k_lim_s;
                        issued_q  <= {KW{1'b0}};
                        out_idx_q <= {OCW{1'b0}};
                        state_q   <= (k_lim_s == {KW{1'b0}}) ? ST_OUTPUT : ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (issue_s) begin
                        issued_q <= issued_q + KW'(1);
                        if ((issued_q + KW'(1)) == k_q) begin
                            drain_q <= {DCW{1'b0}};
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DCW'(ROWS + COLS - 1)) state_q <= ST_OUTPUT;
                    else                                   drain_q <= drain_q + DCW'(1);
                end
                ST_OUTPUT: begin
                    if (out_fire_s) begin
                        if (out_idx_q == OCW'(NOUT - 1)) begin
                            out_idx_q <= {OCW{1'b0}};
                            state_q   <= ST_IDLE;
                        end else begin
                            out_idx_q <= out_idx_q + OCW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_matmul.sv
// Directed bench for systolic_matmul (2x2 array, Q8.8): hand-computed C streams.
module tb_systolic_matmul;
    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int NBITS = 16;
    localparam int DBITS = 8;
    localparam int KMAX  = 16;
    localparam int KW    = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] xq [$];
    logic [15:0] wq [$];
    logic [15:0] got [$];
    int          xi;
    int          wi;
    int          hold_n;
    bit          hold_bad;

    systolic_matmul_if #(.NBITS(NBITS), .KW(KW)) bus ();

    systolic_matmul #(
        .ROWS(ROWS), .COLS(COLS), .NBITS(NBITS), .DBITS(DBITS), .KMAX(KMAX)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.cfg_val = 1'b0; bus.cfg_k = 5'd0; bus.cfg_acc = 1'b0;
        bus.x_recv_val = 1'b0; bus.x_recv_msg = 16'h0000;
        bus.w_recv_val = 1'b0; bus.w_recv_msg = 16'h0000;
        bus.res_send_rdy = 1'b0;
    endtask

    // Runs one job: config handshake, then feeds xq/wq and collects the C stream.
    task automatic run_job(input logic [KW-1:0] k, input logic acc, input bit rnd, input int hold_at);
        int t;
        logic [15:0] held;
        xi = 0; wi = 0; got.delete(); hold_n = 0; hold_bad = 1'b0; held = 16'h0000;
        @(negedge clk);
        bus.cfg_val = 1'b1; bus.cfg_k = k; bus.cfg_acc = acc;
        t = 0;
        while (!bus.cfg_rdy && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        bus.cfg_val = 1'b0;
        t = 0;
        while (got.size() < ROWS*COLS && t < 3000) begin
            if (xi < xq.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
                bus.x_recv_val = 1'b1; bus.x_recv_msg = xq[xi];
            end else begin
                bus.x_recv_val = 1'b0;
            end
            if (bus.x_recv_val && bus.x_recv_rdy) xi++;
            if (wi < wq.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
                bus.w_recv_val = 1'b1; bus.w_recv_msg = wq[wi];
            end else begin
                bus.w_recv_val = 1'b0;
            end
            if (bus.w_recv_val && bus.w_recv_rdy) wi++;
            if (hold_at >= 0 && got.size() == hold_at && hold_n < 5) begin
                bus.res_send_rdy = 1'b0;
                if (bus.res_send_val !== 1'b1) hold_bad = 1'b1;
                if (hold_n == 0) held = bus.res_send_msg;
                else if (bus.res_send_msg !== held) hold_bad = 1'b1;
                hold_n++;
            end else begin
                bus.res_send_rdy = (!rnd || $urandom_range(0, 2) != 0);
            end
            if (bus.res_send_val && bus.res_send_rdy) got.push_back(bus.res_send_msg);
            @(negedge clk);
            t++;
        end
        bus.x_recv_val = 1'b0; bus.w_recv_val = 1'b0; bus.res_send_rdy = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.cfg_rdy, bus.x_recv_rdy, bus.w_recv_rdy, bus.res_send_val, busy} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {bus.cfg_rdy, bus.x_recv_rdy, bus.w_recv_rdy, bus.res_send_val, busy});
        end
        checks++;
        if (bus.res_send_msg !== 16'h0000) begin
            failures++; $display("FAIL reset_msg got=%h want=0000", bus.res_send_msg);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.cfg_rdy !== 1'b1) begin
            failures++; $display("FAIL reset_cfg_rdy got=%b want=1", bus.cfg_rdy);
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp [4];
        xq = '{16'h0100, 16'h0200};
        wq = '{16'h0300, 16'h0400};
        exp = '{16'h0300, 16'h0400, 16'h0600, 16'h0800};
        run_job(5'd1, 1'b0, 1'b0, -1);
        checks++;
        if (xi != 2 || wi != 2 || got.size() != 4) begin
            failures++; $display("FAIL basic_counts got x=%0d w=%0d c=%0d want 2 2 4", xi, wi, got.size());
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (n >= got.size() || got[n] !== exp[n]) begin
                failures++; $display("FAIL basic_c%0d got=%h want=%h", n, (n < got.size()) ? got[n] : 16'hxxxx, exp[n]);
            end
        end
    endtask

    task automatic test_accumulate();
        logic [15:0] exp [4];
        xq = '{16'h0100, 16'h0200};
        wq = '{16'h0300, 16'h0400};
        exp = '{16'h0600, 16'h0800, 16'h0C00, 16'h1000};
        run_job(5'd1, 1'b1, 1'b0, -1);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (n >= got.size() || got[n] !== exp[n]) begin
                failures++; $display("FAIL acc_c%0d got=%h want=%h", n, (n < got.size()) ? got[n] : 16'hxxxx, exp[n]);
            end
        end
        run_job(5'd0, 1'b0, 1'b0, -1);
        checks++;
        if (xi != 0 || wi != 0) begin
            failures++; $display("FAIL k0_consumed got x=%0d w=%0d want 0 0", xi, wi);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (n >= got.size() || got[n] !== 16'h0000) begin
                failures++; $display("FAIL k0_c%0d got=%h want=0000", n, (n < got.size()) ? got[n] : 16'hxxxx);
            end
        end
    endtask

    task automatic test_sign_wrap();
        logic [15:0] exp [3][4];
        xq = '{16'hFF00, 16'h7F00};
        wq = '{16'h0080, 16'h0200};
        exp[0] = '{16'hFF80, 16'hFE00, 16'h3F80, 16'hFE00};
        exp[1] = '{16'hFF00, 16'hFC00, 16'h7F00, 16'hFC00};
        exp[2] = '{16'hFE80, 16'hFA00, 16'hBE80, 16'hFA00};
        for (int j = 0; j < 3; j++) begin
            run_job(5'd1, (j != 0), 1'b0, -1);
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (n >= got.size() || got[n] !== exp[j][n]) begin
                    failures++;
                    $display("FAIL sign_j%0d_c%0d got=%h want=%h", j, n, (n < got.size()) ? got[n] : 16'hxxxx, exp[j][n]);
                end
            end
        end
    endtask

    task automatic test_kmax();
        logic [15:0] exp [4];
        xq.delete(); wq.delete();
        for (int v = 0; v < 20; v++) begin
            xq.push_back((v < 16) ? 16'h0100 : 16'h0300);
            xq.push_back((v < 16) ? 16'h0200 : 16'h0300);
            wq.push_back((v < 16) ? 16'h0100 : 16'h0300);
            wq.push_back((v < 16) ? 16'h0080 : 16'h0300);
        end
        exp = '{16'h1000, 16'h0800, 16'h2000, 16'h1000};
        run_job(5'd20, 1'b0, 1'b0, -1);
        checks++;
        if (xi != 32 || wi != 32) begin
            failures++; $display("FAIL kmax_consumed got x=%0d w=%0d want 32 32", xi, wi);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (n >= got.size() || got[n] !== exp[n]) begin
                failures++; $display("FAIL kmax_c%0d got=%h want=%h", n, (n < got.size()) ? got[n] : 16'hxxxx, exp[n]);
            end
        end
    endtask

    task automatic test_stalls();
        logic [15:0] exp [4];
        xq = '{16'h0100, 16'h0200, 16'h0080, 16'hFF00, 16'h0200, 16'h0100};
        wq = '{16'h0100, 16'h0300, 16'h0200, 16'h0100, 16'h0040, 16'hFF00};
        exp = '{16'h0280, 16'h0180, 16'h0040, 16'h0400};
        run_job(5'd3, 1'b0, 1'b1, 2);
        checks++;
        if (hold_n != 5 || hold_bad) begin
            failures++; $display("FAIL stall_hold got cycles=%0d bad=%0d want 5 0", hold_n, hold_bad);
        end
        checks++;
        if (xi != 6 || wi != 6 || got.size() != 4) begin
            failures++; $display("FAIL stall_counts got x=%0d w=%0d c=%0d want 6 6 4", xi, wi, got.size());
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (n >= got.size() || got[n] !== exp[n]) begin
                failures++; $display("FAIL stall_c%0d got=%h want=%h", n, (n < got.size()) ? got[n] : 16'hxxxx, exp[n]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int xn;
        int wn;
        logic [15:0] exp [4];
        @(negedge clk);
        bus.cfg_val = 1'b1; bus.cfg_k = 5'd3; bus.cfg_acc = 1'b0;
        t = 0;
        while (!bus.cfg_rdy && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        bus.cfg_val = 1'b0;
        xn = 0; wn = 0; t = 0;
        while ((xn < 2 || wn < 2) && t < 100) begin
            bus.x_recv_val = (xn < 2); bus.x_recv_msg = 16'h0500;
            if (bus.x_recv_val && bus.x_recv_rdy) xn++;
            bus.w_recv_val = (wn < 2); bus.w_recv_msg = 16'h0500;
            if (bus.w_recv_val && bus.w_recv_rdy) wn++;
            @(negedge clk);
            t++;
        end
        bus.x_recv_val = 1'b0; bus.w_recv_val = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.x_recv_rdy !== 1'b1 || bus.w_recv_rdy !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got xr=%b wr=%b busy=%b want 1 1 1", bus.x_recv_rdy, bus.w_recv_rdy, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.cfg_rdy, bus.x_recv_rdy, bus.w_recv_rdy, bus.res_send_val, busy} !== 5'b00000) begin
            failures++;
            $display("FAIL mid_rst_drop got=%b want=00000",
                     {bus.cfg_rdy, bus.x_recv_rdy, bus.w_recv_rdy, bus.res_send_val, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        xq = '{16'h0100, 16'h0200};
        wq = '{16'h0300, 16'h0400};
        exp = '{16'h0300, 16'h0400, 16'h0600, 16'h0800};
        run_job(5'd1, 1'b1, 1'b0, -1);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (n >= got.size() || got[n] !== exp[n]) begin
                failures++; $display("FAIL mid_c%0d got=%h want=%h", n, (n < got.size()) ? got[n] : 16'hxxxx, exp[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_sign_wrap();
        test_kmax();
        test_stalls();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
